// File: rtl/uart_rx.sv
// uart_rx: oversampling receiver for 8-data, even-parity, one-stop-bit frames.
// The line is synchronised by two flops and sampled near each bit centre.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       rx_clk,
  input  logic       reset,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] TICK_ONE  = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_sync1, r_rx_s;
  logic [TW-1:0] r_tick, w_tick_nxt;
  logic [2:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_parity, w_parity_nxt;
  logic [7:0]    r_data, w_data_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_perr, w_perr_nxt;
  logic          r_ferr, w_ferr_nxt;
  logic          r_busy, w_busy_nxt;

  // High when data plus received parity bit has odd weight (even parity violated).
  function automatic logic even_parity_err(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge rx_clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= rx_serial;
      r_rx_s  <= r_sync1;
    end
  end

  // Next-state, counter, datapath and status logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_tick_nxt    = r_tick + TICK_ONE;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_parity_nxt  = r_parity;
    w_data_nxt    = r_data;
    w_valid_nxt   = 1'b0;
    w_perr_nxt    = r_perr;
    w_ferr_nxt    = r_ferr;
    case (r_state)
      S_IDLE: begin
        w_tick_nxt = TICK_ZERO;
        if (!r_rx_s) begin
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (r_tick == HALF_TICK) begin
          w_tick_nxt = TICK_ZERO;
          if (r_rx_s) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt   = S_DATA;
            w_bit_cnt_nxt = 3'd0;
          end
        end else begin
          w_state_nxt = S_START;
        end
      end
      S_DATA: begin
        if (r_tick == LAST_TICK) begin
          w_tick_nxt  = TICK_ZERO;
          w_shift_nxt = {r_rx_s, r_shift[7:1]};
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt   = S_PARITY;
            w_bit_cnt_nxt = 3'd0;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      S_PARITY: begin
        if (r_tick == LAST_TICK) begin
          w_tick_nxt   = TICK_ZERO;
          w_parity_nxt = r_rx_s;
          w_state_nxt  = S_STOP;
        end else begin
          w_state_nxt = S_PARITY;
        end
      end
      S_STOP: begin
        if (r_tick == LAST_TICK) begin
          w_tick_nxt  = TICK_ZERO;
          w_data_nxt  = r_shift;
          w_perr_nxt  = even_parity_err(r_shift, r_parity);
          w_ferr_nxt  = ~r_rx_s;
          w_valid_nxt = 1'b1;
          // Leaving mid-stop-bit lets a back-to-back start edge be seen on time.
          if (r_rx_s) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_BREAK;
          end
        end else begin
          w_state_nxt = S_STOP;
        end
      end
      S_BREAK: begin
        w_tick_nxt = TICK_ZERO;
        if (r_rx_s) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_BREAK;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tick_nxt  = TICK_ZERO;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge rx_clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tick    <= TICK_ZERO;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      r_parity  <= 1'b0;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tick    <= w_tick_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_parity  <= w_parity_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_perr    <= w_perr_nxt;
      r_ferr    <= w_ferr_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign rx_data    = r_data;
  assign rx_valid   = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign rx_busy    = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx; expected bytes/status are queued when a
// frame is driven and compared when rx_valid pulses.
module tb_uart_rx;
  localparam int OS  = 16;
  localparam int LAT = 10 * OS + OS / 2 + 3;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_serial;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       rx_busy;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_valid = 0;
  exp_t sb[$];

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .rx_clk    (clk),
    .reset     (reset),
    .rx_serial (rx_serial),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic par, input logic stop, input int nbits);
    logic [10:0] f;
    f = {stop, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rx_serial = f[i];
      repeat (OS) @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_valid(input string tag, input int t0, input logic busy_after);
    exp_t e;
    bit   got;
    got = 1'b0;
    for (int n = 0; n < LAT + 40 && !got; n++) begin
      @(negedge clk);
      if (rx_valid === 1'b1) got = 1'b1;
    end
    chk1({tag, "_seen"}, got, 1'b1);
    chkn({tag, "_sb_nonempty"}, (sb.size() > 0) ? 1 : 0, 1);
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      chkn({tag, "_latency"}, cyc - t0, LAT);
      last_valid = cyc;
      chk8({tag, "_data"}, rx_data, e.data);
      chk1({tag, "_perr"}, parity_err, e.perr);
      chk1({tag, "_ferr"}, frame_err, e.ferr);
      @(negedge clk);
      chk1({tag, "_pulse_end"}, rx_valid, 1'b0);
      chk1({tag, "_busy_after"}, rx_busy, busy_after);
    end
  endtask

  task automatic send_frame(input string tag, input logic [7:0] d, input logic par,
                            input logic stop, input logic busy_after);
    exp_t e;
    int   t0;
    e.data = d;
    e.perr = (^d) ^ par;
    e.ferr = ~stop;
    sb.push_back(e);
    t0 = cyc;
    fork
      drive_frame(d, par, stop, 11);
      expect_valid(tag, t0, busy_after);
    join
  endtask

  initial begin
    int          n_extra;
    int          t_prev;
    logic [7:0]  rdat;

    reset     = 1'b1;
    rx_serial = 1'b1;
    repeat (3) tick1();
    chk8("rst_data", rx_data, 8'h00);
    chk1("rst_valid", rx_valid, 1'b0);
    chk1("rst_perr", parity_err, 1'b0);
    chk1("rst_ferr", frame_err, 1'b0);
    chk1("rst_busy", rx_busy, 1'b0);
    reset = 1'b0;
    repeat (11 * OS + 4) tick1();

    send_frame("a5", 8'hA5, 1'b0, 1'b1, 1'b0);
    repeat (20) tick1();

    send_frame("3c_perr", 8'h3C, 1'b1, 1'b1, 1'b0);
    repeat (20) tick1();
    send_frame("81", 8'h81, 1'b0, 1'b1, 1'b0);
    repeat (20) tick1();

    send_frame("55_brk", 8'h55, 1'b0, 1'b0, 1'b1);
    n_extra = 0;
    for (int i = 0; i < 40; i++) begin
      tick1();
      if (rx_valid === 1'b1) n_extra++;
    end
    chk1("brk_busy_low_line", rx_busy, 1'b1);
    rx_serial = 1'b1;
    tick1();
    chk1("brk_busy_rise1", rx_busy, 1'b1);
    tick1();
    chk1("brk_busy_rise2", rx_busy, 1'b1);
    tick1();
    chk1("brk_busy_rise3", rx_busy, 1'b0);
    chkn("brk_no_second_valid", n_extra, 0);
    chk1("brk_ferr_hold", frame_err, 1'b1);
    repeat (20) tick1();

    n_extra   = 0;
    rx_serial = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick1();
      if (k == 4) rx_serial = 1'b1;
      if (rx_valid === 1'b1) n_extra++;
      if (k == 3) chk1("glitch_busy_e3", rx_busy, 1'b1);
      if (k == 10) chk1("glitch_busy_e10", rx_busy, 1'b1);
      if (k == 11) chk1("glitch_busy_e11", rx_busy, 1'b0);
    end
    chkn("glitch_no_valid", n_extra, 0);
    chk1("glitch_busy_end", rx_busy, 1'b0);
    chk1("glitch_ferr_hold", frame_err, 1'b1);

    send_frame("b2b_00", 8'h00, 1'b0, 1'b1, 1'b0);
    t_prev = last_valid;
    send_frame("b2b_ff", 8'hFF, 1'b0, 1'b1, 1'b0);
    chkn("b2b_spacing", last_valid - t_prev, 11 * OS);
    repeat (30) tick1();

    rdat = 8'hC3;
    drive_frame(rdat, 1'b0, 1'b1, 4);
    rx_serial = rdat[3];
    repeat (6) tick1();
    chk1("mid_busy", rx_busy, 1'b1);
    reset = 1'b1;
    tick1();
    reset     = 1'b0;
    rx_serial = 1'b1;
    chk8("mid_rst_data", rx_data, 8'h00);
    chk1("mid_rst_valid", rx_valid, 1'b0);
    chk1("mid_rst_perr", parity_err, 1'b0);
    chk1("mid_rst_ferr", frame_err, 1'b0);
    chk1("mid_rst_busy", rx_busy, 1'b0);
    n_extra = 0;
    for (int i = 0; i < 11 * OS; i++) begin
      tick1();
      if (rx_valid === 1'b1) n_extra++;
    end
    chkn("mid_rst_no_valid", n_extra, 0);

    send_frame("5a", 8'h5A, 1'b0, 1'b1, 1'b0);
    repeat (10) tick1();
    chkn("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
